seq_alu: RTL and testbench

//  Parametrised, clocked successor to the datapath ALU. Operands and opcode are taken through a

---
 rtl/seq_alu.sv | 161 ++++++++++++++++
 tb/tb_seq_alu.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Clocked ALU with a valid/ready input handshake and registered results/flags.
// MUL, FMUL and DIV iterate one bit per cycle; every other opcode finishes on the accept edge.
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             low,
    output logic             negative,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SH_LIM   = WIDTH'(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_CMP = 4'd2,  OP_CMPR = 4'd3,
        OP_AND  = 4'd4,  OP_OR   = 4'd5,  OP_XOR = 4'd6,  OP_NOT  = 4'd7,
        OP_LSH  = 4'd8,  OP_RSH  = 4'd9,  OP_ARSH = 4'd10,
        OP_MUL  = 4'd11, OP_FMUL = 4'd12, OP_DIV = 4'd13
    } op_t;

    state_t           state, state_n;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] hi, lo;
    logic [CW-1:0]    cnt;
    logic             accept, is_iter, last;

    assign in_ready  = (state != BUSY);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign is_iter   = (opcode == OP_MUL) || (opcode == OP_FMUL) || (opcode == OP_DIV);
    assign last      = (state == BUSY) && (cnt == CNT_LAST);

    logic [WIDTH-1:0] s_c;
    logic             s_low, s_neg, s_zero, sh_big;

    assign sh_big = (a >= SH_LIM);

    always_comb begin
        s_c    = '0;
        s_low  = 1'b0;
        s_neg  = 1'b0;
        s_zero = 1'b0;
        case (opcode)
            OP_ADD:  begin s_c = a + b; s_low = $signed(a) < $signed(b); s_neg = s_c[WIDTH-1]; end
            OP_SUB:  begin s_c = a - b; s_low = $signed(a) < $signed(b); s_neg = s_c[WIDTH-1]; end
            OP_CMP:  begin s_low = a < b; s_neg = $signed(a) < $signed(b); s_zero = (a == b); end
            OP_CMPR: begin s_low = b < a; s_neg = $signed(b) < $signed(a); s_zero = (a == b); end
            OP_AND:  begin s_c = a & b; s_low = a < b; s_neg = s_c[WIDTH-1]; end
            OP_OR:   begin s_c = a | b; s_low = a < b; s_neg = s_c[WIDTH-1]; end
            OP_XOR:  begin s_c = a ^ b; s_low = a < b; s_neg = s_c[WIDTH-1]; end
            OP_NOT:  begin s_c = ~a; s_low = s_c < a; s_neg = s_c[WIDTH-1]; end
            OP_LSH:  s_c = sh_big ? '0 : (b << a);
            OP_RSH:  s_c = sh_big ? '0 : (b >> a);
            OP_ARSH: s_c = sh_big ? {WIDTH{b[WIDTH-1]}} : WIDTH'($signed(b) >>> a);
            default: ;
        endcase
        // Compares report equality instead; illegal opcodes leave every flag clear.
        if ((opcode != OP_CMP) && (opcode != OP_CMPR) && (opcode <= OP_DIV))
            s_zero = (s_c == '0);
    end

    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH-1:0]   mul_hi_n, mul_lo_n, div_rem_n, div_quo_n, it_c, it_d;
    logic [2*WIDTH-1:0] prod_n;
    logic               div_ge;

    // hi:lo is shared: shift-add product for MUL/FMUL, remainder:quotient for DIV.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, a_q} : '0);
        mul_hi_n  = mul_sum[WIDTH:1];
        mul_lo_n  = {mul_sum[0], lo[WIDTH-1:1]};
        prod_n    = {mul_hi_n, mul_lo_n};
        div_shift = {hi, lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        div_rem_n = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
        div_quo_n = {lo[WIDTH-2:0], div_ge};
        it_c      = '0;
        it_d      = '0;
        case (op_q)
            OP_MUL:  begin it_c = mul_lo_n; it_d = mul_hi_n; end
            OP_FMUL: it_c = WIDTH'(prod_n >> FRAC);
            OP_DIV:  begin it_c = div_quo_n; it_d = div_rem_n; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: state_n = accept ? (is_iter ? BUSY : DONE) : IDLE;
            BUSY:       if (last) state_n = DONE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            c        <= '0;
            d        <= '0;
            low      <= 1'b0;
            negative <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            op_q <= opcode;
            a_q  <= a;
            b_q  <= b;
            cnt  <= '0;
            if (is_iter) begin
                hi <= '0;
                lo <= (opcode == OP_DIV) ? a : b;
            end else begin
                c        <= s_c;
                d        <= '0;
                low      <= s_low;
                negative <= s_neg;
                zero     <= s_zero;
            end
        end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
            if (op_q == OP_DIV) begin
                hi <= div_rem_n;
                lo <= div_quo_n;
            end else begin
                hi <= mul_hi_n;
                lo <= mul_lo_n;
            end
            if (last) begin
                c        <= it_c;
                d        <= it_d;
                low      <= 1'b0;
                negative <= 1'b0;
                zero     <= (it_c == '0);
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu (WIDTH=16, FRAC=14): directed cases plus random ops
// checked against an arithmetic reference model.
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  opcode = '0;
    logic [15:0] a = '0, b = '0;
    logic        out_valid;
    logic [15:0] c, d;
    logic        low, negative, zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] c;
        logic [15:0] d;
        logic        low;
        logic        negative;
        logic        zero;
    } result_t;

    logic [3:0] cur_op;
    result_t    expected_res;

    seq_alu #(.WIDTH(16), .FRAC(14)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a(a), .b(b), .out_valid(out_valid),
        .c(c), .d(d), .low(low), .negative(negative), .zero(zero)
    );

    always #5 clk = ~clk;

    function automatic result_t refModel(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        result_t r;
        longint  ux, uy, p;
        int      sx, sy, q, pw;
        ux = x;
        uy = y;
        sx = $signed(x);
        sy = $signed(y);
        r.c = '0; r.d = '0; r.low = 1'b0; r.negative = 1'b0; r.zero = 1'b0;
        case (op)
            4'd0:  begin r.c = 16'((ux + uy) % 65536); r.low = sx < sy; end
            4'd1:  begin r.c = 16'((ux + 65536 - uy) % 65536); r.low = sx < sy; end
            4'd2:  begin r.low = ux < uy; r.negative = sx < sy; r.zero = (ux == uy); end
            4'd3:  begin r.low = uy < ux; r.negative = sy < sx; r.zero = (ux == uy); end
            4'd4:  begin r.c = x & y; r.low = ux < uy; end
            4'd5:  begin r.c = x | y; r.low = ux < uy; end
            4'd6:  begin r.c = x ^ y; r.low = ux < uy; end
            4'd7:  begin r.c = 16'(65535 - ux); r.low = (65535 - ux) < ux; end
            4'd8:  if (ux < 16) r.c = 16'((uy * (longint'(1) << ux)) % 65536);
            4'd9:  if (ux < 16) r.c = 16'(uy / (longint'(1) << ux));
            4'd10: begin
                if (ux >= 16) r.c = (sy < 0) ? 16'hFFFF : 16'h0000;
                else begin
                    pw = 1 << ux;
                    q  = sy / pw;
                    if ((sy % pw != 0) && (sy < 0)) q = q - 1;
                    r.c = 16'(q);
                end
            end
            4'd11: begin p = ux * uy; r.c = 16'(p % 65536); r.d = 16'(p / 65536); end
            4'd12: begin p = ux * uy; r.c = 16'((p / 16384) % 65536); end
            4'd13: begin
                if (uy == 0) begin r.c = 16'hFFFF; r.d = x; end
                else begin r.c = 16'(ux / uy); r.d = 16'(ux % uy); end
            end
            default: ;
        endcase
        if (op inside {4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7}) r.negative = r.c[15];
        if ((op <= 4'd13) && (op != 4'd2) && (op != 4'd3)) r.zero = (r.c == 16'h0000);
        return r;
    endfunction

    task automatic check16(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Called just after a falling edge; returns at the falling edge after the accept edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        int guard;
        cur_op       = op;
        expected_res = refModel(op, x, y);
        opcode       = op;
        a            = x;
        b            = y;
        in_valid     = 1'b1;
        guard        = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkBit($sformatf("op%0d ready_at_accept", op), in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        opcode   = 4'($urandom);
        a        = 16'($urandom);
        b        = 16'($urandom);
    endtask

    task automatic checkOutput(input bit poke);
        int k;
        int busy;
        bit iter;
        iter = cur_op inside {4'd11, 4'd12, 4'd13};
        k    = 1;
        busy = 0;
        while (!out_valid && k < 40) begin
            if (!in_ready) busy++;
            if (poke && k == 2) begin in_valid = 1'b1; opcode = 4'd0; a = 16'h0001; b = 16'h0001; end
            if (poke && k == 6) in_valid = 1'b0;
            @(negedge clk);
            k++;
        end
        in_valid = 1'b0;
        checkBit($sformatf("op%0d out_valid", cur_op), out_valid, 1'b1);
        check16($sformatf("op%0d latency", cur_op), 16'(k), iter ? 16'd17 : 16'd1);
        check16($sformatf("op%0d busy_cycles", cur_op), 16'(busy), iter ? 16'd16 : 16'd0);
        check16($sformatf("op%0d c", cur_op), c, expected_res.c);
        check16($sformatf("op%0d d", cur_op), d, expected_res.d);
        checkBit($sformatf("op%0d low", cur_op), low, expected_res.low);
        checkBit($sformatf("op%0d negative", cur_op), negative, expected_res.negative);
        checkBit($sformatf("op%0d zero", cur_op), zero, expected_res.zero);
    endtask

    initial begin
        logic [3:0]  op;
        logic [15:0] x, y;
        int          pulses;

        $display("[TB] starting seq_alu test");
        repeat (3) @(negedge clk);
        check16("reset c", c, 16'h0000);
        check16("reset d", d, 16'h0000);
        checkBit("reset flags", low | negative | zero, 1'b0);
        checkBit("reset out_valid", out_valid, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        checkBit("ready after reset", in_ready, 1'b1);
        checkBit("idle out_valid", out_valid, 1'b0);

        applyStimulus(4'd0, 16'h7FFF, 16'h0001); checkOutput(1'b0);
        check16("add overflow c", c, 16'h8000);
        checkBit("add overflow negative", negative, 1'b1);

        applyStimulus(4'd11, 16'h1234, 16'h0100); checkOutput(1'b1);
        check16("mul c", c, 16'h3400);
        check16("mul d", d, 16'h0012);
        @(negedge clk);
        checkBit("busy in_valid not queued", out_valid, 1'b0);

        applyStimulus(4'd12, 16'h4000, 16'h6000); checkOutput(1'b0);
        check16("fmul c", c, 16'h6000);
        applyStimulus(4'd13, 16'd100, 16'd7);     checkOutput(1'b0);
        check16("div c", c, 16'd14);
        check16("div d", d, 16'd2);
        applyStimulus(4'd13, 16'd5, 16'd0);       checkOutput(1'b0);
        check16("div0 c", c, 16'hFFFF);
        check16("div0 d", d, 16'd5);

        applyStimulus(4'd10, 16'd4, 16'h8000);    checkOutput(1'b0);
        check16("arsh c", c, 16'hF800);
        applyStimulus(4'd8, 16'd16, 16'hFFFF);    checkOutput(1'b0);
        checkBit("lsh16 zero", zero, 1'b1);
        applyStimulus(4'd9, 16'd1, 16'h0001);     checkOutput(1'b0);
        checkBit("rsh zero", zero, 1'b1);

        // These two are accepted during DONE of the op before them.
        applyStimulus(4'd2, 16'd3, 16'hFFFF);     checkOutput(1'b0);
        checkBit("cmp low", low, 1'b1);
        checkBit("cmp negative", negative, 1'b0);
        applyStimulus(4'd3, 16'd3, 16'hFFFF);     checkOutput(1'b0);
        checkBit("cmpr low", low, 1'b0);
        checkBit("cmpr negative", negative, 1'b1);

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            x  = 16'($urandom);
            y  = 16'($urandom);
            if (op inside {4'd8, 4'd9, 4'd10}) x = 16'($urandom_range(0, 20));
            if (op == 4'd13 && $urandom_range(0, 2) == 0) y = 16'($urandom_range(1, 20));
            if (op == 4'd13 && $urandom_range(0, 4) == 0) y = 16'h0000;
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                checkBit("done lasts one cycle", out_valid, 1'b0);
            end
            applyStimulus(op, x, y);
            checkOutput(1'b0);
        end

        applyStimulus(4'd0, 16'd1, 16'd2); checkOutput(1'b0);
        applyStimulus(4'd11, 16'h1234, 16'h0100);
        repeat (4) @(negedge clk);
        checkBit("mul busy before reset", in_ready, 1'b0);
        reset = 1'b1;
        #1;
        check16("abort c", c, 16'h0000);
        check16("abort d", d, 16'h0000);
        checkBit("abort flags", low | negative | zero, 1'b0);
        checkBit("abort out_valid", out_valid, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkBit("ready after abort", in_ready, 1'b1);
        pulses = 0;
        repeat (20) begin
            if (out_valid) pulses++;
            @(negedge clk);
        end
        check16("aborted op pulses", 16'(pulses), 16'd0);
        applyStimulus(4'd0, 16'h0010, 16'h0020); checkOutput(1'b0);
        check16("add after abort c", c, 16'h0030);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
